// File: rtl/pc_redirect_ctrl.sv
// pc_redirect_ctrl: arbitrates PC redirect requests (trap > jump > branch),
// offers the registered winner to fetch over a valid/ready handshake, drives
// the wrong-path squash window and counts completed redirects (saturating).
//
// Ports:
//   i_clk, i_rst            clock, asynchronous active-low reset
//   i_jmp_valid/_target     jump unit redirect request
//   i_br_valid/_target      taken-branch redirect request
//   i_trap_valid/_target    trap request (never alignment-checked)
//   i_fetch_ready           fetch accepts the offered redirect
//   o_redirect_valid/_pc    registered redirect offer to fetch
//   o_redirect_src          00 none, 01 jump, 10 branch, 11 trap
//   o_squash                discard instruction in decode/execute
//   o_misalign              one-cycle pulse on misaligned jump/branch target
//   o_redirect_cnt          completed redirects, saturating
module pc_redirect_ctrl #(
   parameter int unsigned       XLEN         = 32,
   parameter int unsigned       FLUSH_CYCLES = 2,
   parameter logic [XLEN-1:0]   TRAP_VEC     = XLEN'(32'h0000_0010),
   parameter int unsigned       CNT_W        = 16
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_jmp_valid,
   input  logic [XLEN-1:0]   i_jmp_target,
   input  logic              i_br_valid,
   input  logic [XLEN-1:0]   i_br_target,
   input  logic              i_trap_valid,
   input  logic [XLEN-1:0]   i_trap_target,
   input  logic              i_fetch_ready,
   output logic              o_redirect_valid,
   output logic [XLEN-1:0]   o_redirect_pc,
   output logic [1:0]        o_redirect_src,
   output logic              o_squash,
   output logic              o_misalign,
   output logic [CNT_W-1:0]  o_redirect_cnt
);

   localparam int unsigned FC_W = 4;
   localparam logic [1:0]  SRC_NONE = 2'b00;
   localparam logic [1:0]  SRC_JMP  = 2'b01;
   localparam logic [1:0]  SRC_BR   = 2'b10;
   localparam logic [1:0]  SRC_TRAP = 2'b11;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      PEND  = 2'b01,
      FLUSH = 2'b10
   } state_t;

   state_t            state_q, state_d;
   logic [FC_W-1:0]   flush_q, flush_d;
   logic              valid_d;
   logic [XLEN-1:0]   pc_d;
   logic [1:0]        src_d;
   logic              squash_d;
   logic              mis_d;
   logic [CNT_W-1:0]  cnt_d;

   // Priority-selected request seen in IDLE
   logic              sel_valid;
   logic [XLEN-1:0]   sel_target;
   logic [1:0]        sel_src;
   logic              sel_chk;

   // State and output registers
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         state_q          <= IDLE;
         flush_q          <= '0;
         o_redirect_valid <= 1'b0;
         o_redirect_pc    <= '0;
         o_redirect_src   <= SRC_NONE;
         o_squash         <= 1'b0;
         o_misalign       <= 1'b0;
         o_redirect_cnt   <= '0;
      end else begin
         state_q          <= state_d;
         flush_q          <= flush_d;
         o_redirect_valid <= valid_d;
         o_redirect_pc    <= pc_d;
         o_redirect_src   <= src_d;
         o_squash         <= squash_d;
         o_misalign       <= mis_d;
         o_redirect_cnt   <= cnt_d;
      end
   end

   // Fixed priority trap > jump > branch
   always_comb begin
      sel_valid  = 1'b1;
      sel_target = i_br_target;
      sel_src    = SRC_BR;
      sel_chk    = 1'b1;
      if (i_trap_valid) begin
         sel_target = i_trap_target;
         sel_src    = SRC_TRAP;
         sel_chk    = 1'b0;
      end else if (i_jmp_valid) begin
         sel_target = i_jmp_target;
         sel_src    = SRC_JMP;
      end else if (!i_br_valid) begin
         sel_valid  = 1'b0;
      end
   end

   // Next-state and next-output logic
   always_comb begin
      state_d  = state_q;
      flush_d  = flush_q;
      valid_d  = 1'b0;
      pc_d     = o_redirect_pc;
      src_d    = o_redirect_src;
      squash_d = 1'b0;
      mis_d    = 1'b0;
      cnt_d    = o_redirect_cnt;

      case (state_q)
         IDLE: begin
            if (sel_valid) begin
               state_d = PEND;
               if (sel_chk && (sel_target[1:0] != 2'b00)) begin
                  pc_d  = TRAP_VEC;
                  src_d = SRC_TRAP;
                  mis_d = 1'b1;
               end else begin
                  pc_d  = sel_target;
                  src_d = sel_src;
               end
            end
         end
         PEND: begin
            // A completing handshake beats a same-cycle trap; the trap is
            // then picked up from FLUSH.
            if (o_redirect_valid && i_fetch_ready) begin
               state_d = FLUSH;
               flush_d = FC_W'(FLUSH_CYCLES - 1);
               if (o_redirect_cnt != '1) begin
                  cnt_d = o_redirect_cnt + CNT_W'(1);
               end
            end else if (i_trap_valid && (o_redirect_src != SRC_TRAP)) begin
               pc_d  = i_trap_target;
               src_d = SRC_TRAP;
            end
         end
         FLUSH: begin
            if (i_trap_valid) begin
               state_d = PEND;
               flush_d = '0;
               pc_d    = i_trap_target;
               src_d   = SRC_TRAP;
            end else if (flush_q == '0) begin
               state_d = IDLE;
            end else begin
               flush_d = flush_q - FC_W'(1);
            end
         end
         default: begin
            state_d = IDLE;
            flush_d = '0;
         end
      endcase

      valid_d  = (state_d == PEND);
      squash_d = (state_d != IDLE);
      // Source reads 00 whenever nothing is in flight; pc keeps its value
      if (state_d == IDLE) begin
         src_d = SRC_NONE;
      end
   end

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Self-checking bench for pc_redirect_ctrl: a transaction-level model
// predicts the outputs after each clock and queues them; a monitor pops and
// compares one entry per clock. Directed scenarios are followed by random
// traffic, a mid-redirect reset and counter saturation.
module tb_pc_redirect_ctrl;

   localparam int unsigned XLEN  = 32;
   localparam int unsigned FLUSH = 2;
   localparam logic [31:0] TVEC  = 32'h0000_0010;
   localparam int unsigned CNT_W = 10;
   localparam int          CMAX  = (1 << CNT_W) - 1;

   logic              i_clk = 1'b0;
   logic              i_rst;
   logic              i_jmp_valid, i_br_valid, i_trap_valid, i_fetch_ready;
   logic [XLEN-1:0]   i_jmp_target, i_br_target, i_trap_target;
   logic              o_redirect_valid, o_squash, o_misalign;
   logic [XLEN-1:0]   o_redirect_pc;
   logic [1:0]        o_redirect_src;
   logic [CNT_W-1:0]  o_redirect_cnt;

   pc_redirect_ctrl #(
      .XLEN(XLEN), .FLUSH_CYCLES(FLUSH), .TRAP_VEC(TVEC), .CNT_W(CNT_W)
   ) dut (
      .i_clk(i_clk), .i_rst(i_rst),
      .i_jmp_valid(i_jmp_valid), .i_jmp_target(i_jmp_target),
      .i_br_valid(i_br_valid), .i_br_target(i_br_target),
      .i_trap_valid(i_trap_valid), .i_trap_target(i_trap_target),
      .i_fetch_ready(i_fetch_ready),
      .o_redirect_valid(o_redirect_valid), .o_redirect_pc(o_redirect_pc),
      .o_redirect_src(o_redirect_src), .o_squash(o_squash),
      .o_misalign(o_misalign), .o_redirect_cnt(o_redirect_cnt)
   );

   always #5 i_clk = ~i_clk;

   typedef struct {
      bit          v;
      logic [31:0] pc;
      logic [1:0]  src;
      bit          sq;
      bit          mis;
      int          cnt;
   } exp_t;

   exp_t exp_q[$];
   int   n_pass  = 0;
   int   n_total = 0;

   // Model: a redirect is either offered (m_pend) or inside its squash tail
   // of m_left remaining cycles; otherwise nothing is in flight.
   bit          m_pend;
   int          m_left;
   logic [31:0] m_pc;
   logic [1:0]  m_src;
   int          m_cnt;
   bit          m_mis;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_valid"}, 64'(o_redirect_valid), 64'd0);
      check({tag, "_pc"},    64'(o_redirect_pc),    64'd0);
      check({tag, "_src"},   64'(o_redirect_src),   64'd0);
      check({tag, "_squash"},64'(o_squash),         64'd0);
      check({tag, "_mis"},   64'(o_misalign),       64'd0);
      check({tag, "_cnt"},   64'(o_redirect_cnt),   64'd0);
   endtask

   task automatic model_reset();
      m_pend = 0; m_left = 0; m_pc = '0; m_src = 2'd0; m_cnt = 0; m_mis = 0;
   endtask

   task automatic model_take(input logic [31:0] t, input logic [1:0] s, input bit chk);
      m_pend = 1;
      if (chk && t[1:0] != 2'b00) begin
         m_pc = TVEC; m_src = 2'd3; m_mis = 1;
      end else begin
         m_pc = t; m_src = s;
      end
   endtask

   // Drive one cycle of inputs, advance the model and queue its prediction
   task automatic cyc(input bit jv, input logic [31:0] jt, input bit bv, input logic [31:0] bt,
                      input bit tv, input logic [31:0] tt, input bit rdy);
      exp_t e;
      @(negedge i_clk);
      i_jmp_valid = jv; i_jmp_target = jt;
      i_br_valid = bv;  i_br_target = bt;
      i_trap_valid = tv; i_trap_target = tt;
      i_fetch_ready = rdy;
      m_mis = 0;
      if (m_pend) begin
         if (rdy) begin
            m_pend = 0; m_left = FLUSH;
            if (m_cnt < CMAX) m_cnt++;
         end else if (tv && m_src != 2'd3) begin
            m_pc = tt; m_src = 2'd3;
         end
      end else if (m_left > 0) begin
         if (tv) begin
            m_left = 0; m_pend = 1; m_pc = tt; m_src = 2'd3;
         end else begin
            m_left--;
         end
      end else begin
         if (tv)      model_take(tt, 2'd3, 0);
         else if (jv) model_take(jt, 2'd1, 1);
         else if (bv) model_take(bt, 2'd2, 1);
      end
      e.v   = m_pend;
      e.pc  = m_pc;
      e.sq  = m_pend || (m_left > 0);
      e.src = e.sq ? m_src : 2'd0;
      e.mis = m_mis;
      e.cnt = m_cnt;
      exp_q.push_back(e);
   endtask

   task automatic idle(input int n, input bit rdy);
      for (int k = 0; k < n; k++) cyc(0, 32'h0, 0, 32'h0, 0, 32'h0, rdy);
   endtask

   // Monitor: one expected entry per clock, sampled after the edge settles
   always begin
      exp_t e;
      @(posedge i_clk);
      #1;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check("valid",  64'(o_redirect_valid), 64'(e.v));
         check("pc",     64'(o_redirect_pc),    64'(e.pc));
         check("src",    64'(o_redirect_src),   64'(e.src));
         check("squash", 64'(o_squash),         64'(e.sq));
         check("mis",    64'(o_misalign),       64'(e.mis));
         check("cnt",    64'(o_redirect_cnt),   64'(e.cnt));
      end
   end

   function automatic logic [31:0] rnd_target();
      logic [31:0] t;
      t = $urandom;
      if ($urandom_range(0, 3) != 0) t[1:0] = 2'b00;
      return t;
   endfunction

   initial begin
      i_rst = 1'b0;
      i_jmp_valid = 0; i_br_valid = 0; i_trap_valid = 0; i_fetch_ready = 0;
      i_jmp_target = '0; i_br_target = '0; i_trap_target = '0;
      model_reset();
      #2;
      check_zero("por");
      @(negedge i_clk);
      @(negedge i_clk);
      i_rst = 1'b1;
      idle(2, 0);

      // Jump, fetch ready immediately
      cyc(1, 32'h100, 0, 32'h0, 0, 32'h0, 1);
      idle(4, 1);
      // Branch with fetch stalled three cycles
      cyc(0, 32'h0, 1, 32'h200, 0, 32'h0, 0);
      idle(3, 0);
      idle(4, 1);
      // All three requesters at once
      cyc(1, 32'h100, 1, 32'h200, 1, 32'h80, 0);
      idle(1, 0);
      idle(5, 1);
      // Trap overrides a pending jump
      cyc(1, 32'h100, 0, 32'h0, 0, 32'h0, 0);
      cyc(0, 32'h0, 0, 32'h0, 1, 32'h80, 0);
      idle(1, 0);
      idle(4, 1);
      // Misaligned jump
      cyc(1, 32'h102, 0, 32'h0, 0, 32'h0, 1);
      idle(4, 1);
      // Trap coincident with handshake, then taken from FLUSH
      cyc(0, 32'h0, 1, 32'h300, 0, 32'h0, 0);
      cyc(0, 32'h0, 0, 32'h0, 1, 32'h400, 1);
      cyc(0, 32'h0, 0, 32'h0, 1, 32'h400, 0);
      idle(1, 0);
      idle(4, 1);
      // Wrong-path requests during PEND and FLUSH are ignored
      cyc(0, 32'h0, 1, 32'h500, 0, 32'h0, 0);
      cyc(1, 32'h600, 1, 32'h700, 0, 32'h0, 1);
      cyc(1, 32'h600, 1, 32'h700, 0, 32'h0, 0);
      idle(4, 1);

      // Random traffic
      for (int i = 0; i < 3000; i++) begin
         cyc($urandom_range(0, 5) == 0, rnd_target(),
             $urandom_range(0, 5) == 0, rnd_target(),
             $urandom_range(0, 9) == 0, $urandom,
             $urandom_range(0, 1) == 1);
      end
      idle(6, 1);

      // Reset while a redirect is pending
      cyc(1, 32'h100, 0, 32'h0, 0, 32'h0, 0);
      idle(1, 0);
      @(negedge i_clk);
      i_rst = 1'b0;
      #1;
      check_zero("rst_pend");
      @(negedge i_clk);
      @(negedge i_clk);
      i_rst = 1'b1;
      model_reset();
      idle(4, 1);

      // Counter saturation
      for (int i = 0; i < (CMAX + 8) * 4; i++) cyc(1, 32'h100, 0, 32'h0, 0, 32'h0, 1);
      idle(4, 1);
      @(posedge i_clk);
      #2;
      check("sat_cnt", 64'(o_redirect_cnt), 64'(CMAX));
      check("queue_drained", 64'(exp_q.size()), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
